// File: rtl/prienc_pkg.sv
// Shared state encoding and priority-encode helper for the am_prio_int_encoder family.
// The helper works on up to 32 lines; callers zero-extend and slice to their own width.
package prienc_pkg;

   localparam int PRIO_MAX_N = 32;
   localparam int PRIO_MAX_W = 5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SVC  = 2'd2;

   // Highest set index wins; all-zero input yields 0.
   function automatic logic [PRIO_MAX_W-1:0] prio_enc(input logic [PRIO_MAX_N-1:0] v);
      logic [PRIO_MAX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < PRIO_MAX_N; i++) begin
         if (v[i]) idx = PRIO_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/prienc_core.sv
// Combinational priority encoder over the effective (pending & ~mask) lines.
// Produces the winning index and an any-valid flag.
module prienc_core
   import prienc_pkg::*;
#(
   parameter int N  = 8,
   parameter int VW = $clog2(N)
) (
   input  logic [N-1:0]  eff,
   output logic [VW-1:0] idx,
   output logic          any
);

   logic [PRIO_MAX_W-1:0] wide_idx;

   assign wide_idx = prio_enc(PRIO_MAX_N'(eff));
   assign idx      = wide_idx[VW-1:0];
   assign any      = |eff;

endmodule

// File: rtl/am_prio_int_encoder.sv
// Registered 8-to-3 priority interrupt encoder with iack/EOI handshake.
// Define PRIENC_CASCADE_EN to add the 74LS148-style ei_/eo_/gs_ cascade ports.
//
// state  | meaning
// S_IDLE | no offer outstanding; offers highest eff line when enabled
// S_REQ  | int_ low, vec frozen, waiting for iack (or withdraw on mask)
// S_SVC  | acknowledged, busy high until eoi; no nesting
module am_prio_int_encoder
   import prienc_pkg::*;
#(
   parameter int N  = 8,
   parameter int VW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_,
   input  logic          mask_we,
   input  logic [N-1:0]  din,
   input  logic          iack,
   input  logic          eoi,
`ifdef PRIENC_CASCADE_EN
   input  logic          ei_,
   output logic          eo_,
   output logic          gs_,
`endif
   output logic          int_,
   output logic [VW-1:0] vec,
   output logic          busy,
   output logic [N-1:0]  pend
);

   logic [1:0]    state, state_nxt;
   logic          int_nxt, busy_nxt;
   logic [VW-1:0] vec_nxt;
   logic [N-1:0]  prev_req, mask, set, clr, eff;
   logic [VW-1:0] win_idx;
   logic          win_any;
   logic          armed;
   logic          ei_blk;

`ifdef PRIENC_CASCADE_EN
   assign ei_blk = ei_;
   assign eo_    = ei_ | win_any;
   assign gs_    = (state != S_REQ);
`else
   assign ei_blk = 1'b0;
`endif

   // The first cycle after reset only loads prev_req, so a line held low
   // through reset is treated as already asserted rather than as a new edge.
   assign set = armed ? (prev_req & ~req_) : '0;
   assign clr = (state == S_REQ && iack) ? ({{(N-1){1'b0}}, 1'b1} << vec) : '0;
   assign eff = pend & ~mask;

   prienc_core #(.N(N), .VW(VW)) u_core (
      .eff (eff),
      .idx (win_idx),
      .any (win_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_req <= '1;
         pend     <= '0;
         mask     <= '0;
         armed    <= 1'b0;
      end else begin
         prev_req <= req_;
         pend     <= (pend & ~clr) | set;
         armed    <= 1'b1;
         if (mask_we) mask <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         int_  <= 1'b1;
         vec   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         int_  <= int_nxt;
         vec   <= vec_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      int_nxt   = int_;
      vec_nxt   = vec;
      busy_nxt  = busy;
      case (state)
         S_IDLE: begin
            if (win_any && !ei_blk) begin
               state_nxt = S_REQ;
               vec_nxt   = win_idx;
               int_nxt   = 1'b0;
            end
         end
         S_REQ: begin
            // iack takes precedence over a same-cycle withdraw
            if (iack) begin
               state_nxt = S_SVC;
               int_nxt   = 1'b1;
               busy_nxt  = 1'b1;
            end else if (!eff[vec]) begin
               state_nxt = S_IDLE;
               int_nxt   = 1'b1;
            end
         end
         S_SVC: begin
            if (eoi) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            int_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_am_prio_int_encoder.sv
// Directed self-checking bench for am_prio_int_encoder (N=8).
// Cascade checks run only when PRIENC_CASCADE_EN is defined.
module tb_am_prio_int_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_;
   logic       mask_we;
   logic [7:0] din;
   logic       iack;
   logic       eoi;
   logic       int_;
   logic [2:0] vec;
   logic       busy;
   logic [7:0] pend;
`ifdef PRIENC_CASCADE_EN
   logic       ei_;
   logic       eo_;
   logic       gs_;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   am_prio_int_encoder dut (
      .clk     (clk),
      .rst     (rst),
      .req_    (req_),
      .mask_we (mask_we),
      .din     (din),
      .iack    (iack),
      .eoi     (eoi),
`ifdef PRIENC_CASCADE_EN
      .ei_     (ei_),
      .eo_     (eo_),
      .gs_     (gs_),
`endif
      .int_    (int_),
      .vec     (vec),
      .busy    (busy),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_iack();
      iack = 1'b1; tick(); iack = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1; tick(); eoi = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_ = 8'hFE; mask_we = 1'b0; din = 8'h00; iack = 1'b0; eoi = 1'b0;
`ifdef PRIENC_CASCADE_EN
      ei_ = 1'b0;
`endif
      // 1: reset values; line 0 held low through reset posts nothing
      tick(3);
      chk("rst_int", int_, 1); chk("rst_vec", vec, 0);
      chk("rst_busy", busy, 0); chk("rst_pend", pend, 8'h00);
      @(negedge clk); rst = 1'b0;
      tick(3);
      chk("held_low_pend", pend, 8'h00); chk("held_low_int", int_, 1);
      req_ = 8'hFF; tick(2);

      // stray pulses in S_IDLE are ignored
      pulse_iack(); pulse_eoi(); tick();
      chk("stray_busy", busy, 0); chk("stray_int", int_, 1);

      // 2: single line 3
      req_ = 8'hF7; tick();
      chk("t2_pend", pend, 8'h08); chk("t2_int_early", int_, 1);
      tick();
      chk("t2_int", int_, 0); chk("t2_vec", vec, 3);
      pulse_iack();
      chk("t2_pend_clr", pend, 8'h00); chk("t2_busy", busy, 1); chk("t2_int_hi", int_, 1);
      tick();
      chk("t2_busy_hold", busy, 1);
      pulse_eoi();
      chk("t2_busy_done", busy, 0);
      req_ = 8'hFF; tick(2);

      // 3: lines 6 and 2 together
      req_ = 8'hBB; tick();
      chk("t3_pend", pend, 8'h44);
      tick();
      chk("t3_vec6", vec, 6); chk("t3_int6", int_, 0);
      pulse_iack();
      chk("t3_pend_after", pend, 8'h04);
      pulse_eoi();
      chk("t3_idle_int", int_, 1); chk("t3_idle_busy", busy, 0);
      tick();
      chk("t3_vec2", vec, 2); chk("t3_int2", int_, 0);
      pulse_iack(); pulse_eoi();
      chk("t3_pend_empty", pend, 8'h00);
      req_ = 8'hFF; tick(2);

      // 4: mask withdraws an offer, unmask re-offers
      req_ = 8'hBF; tick(2);
      chk("t4_vec", vec, 6); chk("t4_int", int_, 0);
      mask_we = 1'b1; din = 8'h40; tick(); mask_we = 1'b0;
      tick();
      chk("t4_withdraw", int_, 1); chk("t4_pend_kept", pend, 8'h40);
      tick();
      chk("t4_stay_idle", int_, 1);
      mask_we = 1'b1; din = 8'h00; tick(); mask_we = 1'b0;
      tick();
      chk("t4_reoffer_int", int_, 0); chk("t4_reoffer_vec", vec, 6);
      pulse_iack(); pulse_eoi();
      req_ = 8'hFF; tick(2);

      // 5: line 5 re-posts in the iack cycle of vec=5
      req_ = 8'hDF; tick();
      req_ = 8'hFF; tick();
      chk("t5_vec", vec, 5); chk("t5_int", int_, 0);
      req_ = 8'hDF; iack = 1'b1; tick(); iack = 1'b0;
      chk("t5_pend_kept", pend, 8'h20); chk("t5_busy", busy, 1);
      pulse_eoi();
      chk("t5_busy_done", busy, 0);
      tick();
      chk("t5_reoffer_int", int_, 0); chk("t5_reoffer_vec", vec, 5);
      pulse_iack(); pulse_eoi();
      req_ = 8'hFF; tick(2);

`ifdef PRIENC_CASCADE_EN
      // 6: cascade enable gating
      ei_ = 1'b1; req_ = 8'hFE; tick();
      chk("t6_pend", pend, 8'h01);
      tick(2);
      chk("t6_int_blocked", int_, 1); chk("t6_eo_hi", eo_, 1); chk("t6_gs_hi", gs_, 1);
      ei_ = 1'b0; tick();
      chk("t6_gs_lo", gs_, 0); chk("t6_int_lo", int_, 0); chk("t6_vec", vec, 0);
      pulse_iack(); pulse_eoi();
      chk("t6_eo_lo", eo_, 0);
      req_ = 8'hFF; tick(2);
`endif

      // reset mid-operation drops the in-flight request immediately
      req_ = 8'hEF; tick(2);
      chk("t7_int_pre", int_, 0); chk("t7_vec_pre", vec, 4);
      #2 rst = 1'b1; #1;
      chk("t7_int_rst", int_, 1); chk("t7_pend_rst", pend, 8'h00); chk("t7_vec_rst", vec, 0);
      req_ = 8'hFF;
      @(negedge clk); rst = 1'b0;
      tick(3);
      chk("t7_lost", pend, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
